traffic_controller: RTL

- Frame-rate sequencer for the game playfield. It owns lane car positions car_x1..car_x4 and the top-level game state; color_generation consumes these outputs.
- Per lane, it advances car positions once every FRAME_DIV frames, wrapping at the screen edge.
- It detects player/car collision and goal reach during vertical blanking.
- It drives lives, level, a player freeze and a one-cycle player_reset pulse.

---
 rtl/traffic_controller_pkg.sv | 29 ++
 rtl/traffic_controller_lane.sv | 64 ++++++
 rtl/traffic_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/traffic_controller_pkg.sv
// Shared screen geometry, lane/player sizes and game-state encoding for the
// traffic controller and its lane movers.
package traffic_controller_pkg;

  localparam logic [9:0] H_DISPLAY     = 10'd640;
  localparam logic [9:0] V_DISPLAY     = 10'd480;

  localparam logic [9:0] CAR_WIDTH     = 10'd32;
  localparam logic [9:0] CAR_HEIGHT    = 10'd32;
  localparam logic [9:0] CAR_Y1        = 10'd24;
  localparam logic [9:0] CAR_Y2        = 10'd120;
  localparam logic [9:0] CAR_Y3        = 10'd216;
  localparam logic [9:0] CAR_Y4        = 10'd312;

  localparam logic [9:0] PLAYER_WIDTH  = 10'd16;
  localparam logic [9:0] PLAYER_HEIGHT = 10'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  function automatic logic [2:0] level_inc(input logic [2:0] lvl);
    return (lvl == 3'd7) ? lvl : lvl + 3'd1;
  endfunction

endpackage

// File: rtl/traffic_controller_lane.sv
// lane_mover: one lane's car position with screen-edge wrap and the
// player/car box-overlap test against that lane's car.
module lane_mover
  import traffic_controller_pkg::*;
#(
  parameter bit         DIR_LEFT = 1'b0,
  parameter logic [9:0] INIT     = 10'd0,
  parameter logic [3:0] SPEED    = 4'd1,
  parameter logic [9:0] CAR_Y    = 10'd0,
  parameter bit         ACTIVE   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] level,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] car_x,
  output logic       hit
);

  logic [9:0]  car_x_q, car_x_d;
  logic [3:0]  spd;
  logic [10:0] cx, sum, nxt;
  logic [10:0] px, py, cy;

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    spd = SPEED + {1'b0, level};
    cx  = {1'b0, car_x_q};
    sum = cx + {7'd0, spd};
    nxt = sum;
    if (DIR_LEFT) begin
      if (cx < {7'd0, spd}) nxt = cx + {1'b0, H_DISPLAY} - {7'd0, spd};
      else                  nxt = cx - {7'd0, spd};
    end else if (sum >= {1'b0, H_DISPLAY}) begin
      nxt = sum - {1'b0, H_DISPLAY};
    end

    car_x_d = car_x_q;
    if (load)                 car_x_d = INIT;
    else if (step && ACTIVE)  car_x_d = nxt[9:0];
  end

  // Strict box overlap, no wrap-around; 11 bits keeps right/bottom edges exact.
  always_comb begin
    px  = {1'b0, player_x};
    py  = {1'b0, player_y};
    cy  = {1'b0, CAR_Y};
    hit = ACTIVE
       && (px < cx + {1'b0, CAR_WIDTH})  && (cx < px + {1'b0, PLAYER_WIDTH})
       && (py < cy + {1'b0, CAR_HEIGHT}) && (cy < py + {1'b0, PLAYER_HEIGHT});
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) car_x_q <= INIT;
    else        car_x_q <= car_x_d;
  end

  assign car_x = car_x_q;

endmodule

// File: rtl/traffic_controller.sv
// Frame-rate game sequencer: lane car motion, collision/goal decisions, lives
// and level. Optional macro FOUR_LANES_EN enables lanes 3 and 4.
module traffic_controller
  import traffic_controller_pkg::*;
#(
  parameter int unsigned NUM_LIVES   = 3,
  parameter int unsigned FRAME_DIV   = 2,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned GOAL_Y      = 32,
  parameter int unsigned SPEED1      = 1,
  parameter int unsigned SPEED2      = 2,
  parameter int unsigned SPEED3      = 3,
  parameter int unsigned SPEED4      = 2,
  parameter int unsigned CAR_X1_INIT = 0,
  parameter int unsigned CAR_X2_INIT = 320,
  parameter int unsigned CAR_X3_INIT = 160,
  parameter int unsigned CAR_X4_INIT = 480
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  input  logic       start,
  output logic [9:0] car_x1,
  output logic [9:0] car_x2,
  output logic [9:0] car_x3,
  output logic [9:0] car_x4,
  output logic [1:0] game_state,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       freeze,
  output logic       player_reset
);

`ifdef FOUR_LANES_EN
  localparam bit LANES34_ON = 1'b1;
`else
  localparam bit LANES34_ON = 1'b0;
`endif

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES - 1);

  game_state_e state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic [3:0]  div_q, div_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic        start_q, tick_q, tick_d, preset_q, preset_d;
  logic        start_rise, step, load;
  logic [3:0]  lane_hit;

  lane_mover #(.DIR_LEFT(1'b0), .INIT(10'(CAR_X1_INIT)), .SPEED(4'(SPEED1)), .CAR_Y(CAR_Y1), .ACTIVE(1'b1))
    u_lane1 (.CLK(CLK), .RST_N(RST_N), .step(step), .load(load), .level(level_q),
             .player_x(player_x), .player_y(player_y), .car_x(car_x1), .hit(lane_hit[0]));
  lane_mover #(.DIR_LEFT(1'b1), .INIT(10'(CAR_X2_INIT)), .SPEED(4'(SPEED2)), .CAR_Y(CAR_Y2), .ACTIVE(1'b1))
    u_lane2 (.CLK(CLK), .RST_N(RST_N), .step(step), .load(load), .level(level_q),
             .player_x(player_x), .player_y(player_y), .car_x(car_x2), .hit(lane_hit[1]));
  lane_mover #(.DIR_LEFT(1'b0), .INIT(10'(CAR_X3_INIT)), .SPEED(4'(SPEED3)), .CAR_Y(CAR_Y3), .ACTIVE(LANES34_ON))
    u_lane3 (.CLK(CLK), .RST_N(RST_N), .step(step), .load(load), .level(level_q),
             .player_x(player_x), .player_y(player_y), .car_x(car_x3), .hit(lane_hit[2]));
  lane_mover #(.DIR_LEFT(1'b1), .INIT(10'(CAR_X4_INIT)), .SPEED(4'(SPEED4)), .CAR_Y(CAR_Y4), .ACTIVE(LANES34_ON))
    u_lane4 (.CLK(CLK), .RST_N(RST_N), .step(step), .load(load), .level(level_q),
             .player_x(player_x), .player_y(player_y), .car_x(car_x4), .hit(lane_hit[3]));

  assign tick_d     = (h_count == 10'd0) && (v_count == V_DISPLAY);
  assign start_rise = start && !start_q;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    div_d     = div_q;
    hit_cnt_d = hit_cnt_q;
    preset_d  = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d  = ST_PLAY;
          lives_d  = 2'(NUM_LIVES);
          level_d  = 3'd0;
          div_d    = 4'd0;
          load     = 1'b1;
          preset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick_q) begin
          div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
          // Collision outranks goal; lanes only move on a tick with neither.
          if (|lane_hit) begin
            state_d   = ST_HIT;
            hit_cnt_d = 8'd0;
          end else if (player_y < 10'(GOAL_Y)) begin
            level_d  = level_inc(level_q);
            preset_d = 1'b1;
          end else begin
            step = (div_q == DIV_LAST);
          end
        end
      end
      ST_HIT: begin
        if (tick_q) begin
          if (hit_cnt_q == HIT_LAST) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = ST_OVER;
            end else begin
              state_d  = ST_PLAY;
              preset_d = 1'b1;
            end
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      lives_q   <= 2'd0;
      level_q   <= 3'd0;
      div_q     <= 4'd0;
      hit_cnt_q <= 8'd0;
      start_q   <= 1'b0;
      tick_q    <= 1'b0;
      preset_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      div_q     <= div_d;
      hit_cnt_q <= hit_cnt_d;
      start_q   <= start;
      tick_q    <= tick_d;
      preset_q  <= preset_d;
    end
  end

  assign game_state   = state_q;
  assign lives        = lives_q;
  assign level        = level_q;
  assign freeze       = (state_q != ST_PLAY);
  assign player_reset = preset_q;

endmodule
